// File: rtl/mem_unit_pkg.sv
// Shared types and helpers for the memory access unit.
//   mem_size_e       access width encoding of req_size
//   mu_state_e       controller states
//   size_to_bytenum  access width -> byte count presented on the bus
//   is_misaligned    natural-alignment test for half/word accesses
package mem_unit_pkg;

    localparam int COMMON_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_WR_WAIT  = 3'd4,
        ST_RESP     = 3'd5
    } mu_state_e;

    function automatic logic [2:0] size_to_bytenum(input mem_size_e size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lsb);
        case (size)
            SIZE_HALF: return addr_lsb[0];
            SIZE_WORD: return addr_lsb != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rom_inf.sv
// Memory request interface. One instance carries either reads or writes.
//   addr      byte address
//   data      read data (memory -> unit) or write data (unit -> memory)
//   byte_num  bytes in the access: 1, 2 or 4
//   en        access request level, held until done or abort
//   done      completion level from the memory
interface rom_inf;
    logic [mem_unit_pkg::COMMON_W-1:0] addr;
    logic [mem_unit_pkg::COMMON_W-1:0] data;
    logic [2:0]                        byte_num;
    logic                              en;
    logic                              done;

    modport unit_read  (output addr, byte_num, en, input data, done);
    modport unit_write (output addr, data, byte_num, en, input done);
    modport mem_read   (input addr, byte_num, en, output data, done);
    modport mem_write  (input addr, data, byte_num, en, output done);
endinterface

// File: rtl/load_extend.sv
// Combinational load-data extension.
//   data       raw word from memory, loaded value low-aligned
//   size       access width
//   is_signed  1: replicate the msb of the loaded value, 0: zero fill
//   result     extended 32-bit value
module load_extend
    import mem_unit_pkg::*;
(
    input  logic [COMMON_W-1:0] data,
    input  mem_size_e           size,
    input  logic                is_signed,
    output logic [COMMON_W-1:0] result
);

    always_comb begin
        result = data;
        case (size)
            SIZE_BYTE: result = {{24{is_signed & data[7]}}, data[7:0]};
            SIZE_HALF: result = {{16{is_signed & data[15]}}, data[15:0]};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: turns one pipeline request into a single read or
// write transaction on rom_inf and returns extended load data or store
// completion, with alignment checking and a bounded wait.
//   clk, rst        clock, asynchronous active-high reset
//   req_*           request handshake and fields (accepted only in IDLE)
//   flush           abort an in-flight bus access without a response
//   resp_*          response handshake, load data and error flag
//   rd, wr          read and write memory ports
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | ready for a request
// ST_RD_ISSUE  | rd.en first cycle; done ignored (may be stale)
// ST_RD_WAIT   | rd.en held, waiting for done or timeout
// ST_WR_ISSUE  | wr.en first cycle; done ignored (may be stale)
// ST_WR_WAIT   | wr.en held, waiting for done or timeout
// ST_RESP      | response held until resp_ready
module mem_access_unit
    import mem_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          CHECK_ALIGN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [COMMON_W-1:0] req_addr,
    input  logic [COMMON_W-1:0] req_wdata,
    input  logic                flush,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [COMMON_W-1:0] resp_rdata,
    output logic                resp_err,
    rom_inf.unit_read           rd,
    rom_inf.unit_write          wr
);

    mu_state_e           state_q, state_d;
    mem_size_e           size_q, size_d;
    logic                signed_q, signed_d;
    logic [COMMON_W-1:0] addr_q, addr_d;
    logic [COMMON_W-1:0] wdata_q, wdata_d;
    logic [2:0]          bytenum_q, bytenum_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                resp_valid_q, resp_valid_d;
    logic [COMMON_W-1:0] resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         wait_cnt_q, wait_cnt_d;

    logic [COMMON_W-1:0] ext_data;
    logic [31:0]         cnt_inc;
    logic                timeout_hit;
    logic                req_illegal;

    load_extend u_load_extend (
        .data      (rd.data),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (ext_data)
    );

    // Saturating count of WAIT cycles; a timeout fires on the WAIT cycle
    // that brings the count to TIMEOUT_CYCLES, unless done arrives with it.
    assign cnt_inc     = (wait_cnt_q == 32'hFFFF_FFFF) ? wait_cnt_q : wait_cnt_q + 32'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= TIMEOUT_CYCLES);

    assign req_illegal = (req_size == 2'd3) ||
                         (CHECK_ALIGN && is_misaligned(mem_size_e'(req_size), req_addr[1:0]));

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        bytenum_d    = bytenum_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d     = mem_size_e'(req_size);
                    signed_d   = req_signed;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    bytenum_d  = size_to_bytenum(mem_size_e'(req_size));
                    wait_cnt_d = 32'd0;
                    if (req_illegal) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_we) begin
                        state_d = ST_WR_ISSUE;
                        wr_en_d = 1'b1;
                    end else begin
                        state_d = ST_RD_ISSUE;
                        rd_en_d = 1'b1;
                    end
                end
            end

            ST_RD_ISSUE, ST_WR_ISSUE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                end else begin
                    state_d = (state_q == ST_RD_ISSUE) ? ST_RD_WAIT : ST_WR_WAIT;
                end
            end

            ST_RD_WAIT, ST_WR_WAIT: begin
                wait_cnt_d = cnt_inc;
                if (flush) begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                end else if ((state_q == ST_RD_WAIT) ? rd.done : wr.done) begin
                    state_d      = ST_RESP;
                    rd_en_d      = 1'b0;
                    wr_en_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = (state_q == ST_RD_WAIT) ? ext_data : '0;
                end else if (timeout_hit) begin
                    state_d      = ST_RESP;
                    rd_en_d      = 1'b0;
                    wr_en_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            size_q       <= SIZE_BYTE;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bytenum_q    <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            bytenum_q    <= bytenum_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Gated by rst so the pipeline never sees ready while reset is held.
    assign req_ready   = (state_q == ST_IDLE) && !rst;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

    assign rd.en       = rd_en_q;
    assign rd.addr     = addr_q;
    assign rd.byte_num = bytenum_q;
    assign wr.en       = wr_en_q;
    assign wr.addr     = addr_q;
    assign wr.byte_num = bytenum_q;
    assign wr.data     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we, req_signed, flush;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    rom_inf rd_if ();
    rom_inf wr_if ();

    mem_access_unit #(.TIMEOUT_CYCLES(TO), .CHECK_ALIGN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .rd         (rd_if),
        .wr         (wr_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    exp_t exp_q[$];

    // memory behaviour for the current transaction
    int          mem_delay = 0;
    logic [31:0] mem_data  = 0;
    bit          mem_stuck = 0;
    bit          exp_bus   = 0;
    bit          exp_read  = 0;
    logic [31:0] exp_addr  = 0;
    logic [31:0] exp_wdata = 0;
    logic [2:0]  exp_bn    = 0;
    bit          hold_ready = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tb_illegal(input int size, input logic [31:0] addr);
        return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    endfunction

    // Reference: what the pipeline should receive for one request.
    function automatic exp_t ref_resp(input bit we, input int size, input bit sgn,
                                      input logic [31:0] addr, input logic [31:0] md, input int d);
        exp_t e;
        e.err = 0;
        e.rdata = 0;
        if (tb_illegal(size, addr) || d >= TO) begin
            e.err = 1;
            return e;
        end
        if (!we) begin
            case (size)
                0: begin
                    e.rdata = md % 256;
                    if (sgn && e.rdata >= 128) e.rdata = e.rdata + 32'hFFFF_FF00;
                end
                1: begin
                    e.rdata = md % 65536;
                    if (sgn && e.rdata >= 32768) e.rdata = e.rdata + 32'hFFFF_0000;
                end
                default: e.rdata = md;
            endcase
        end
        return e;
    endfunction

    // Memory responder: done on the (d+1)-th WAIT cycle, garbage data otherwise.
    initial begin : responder
        int en_cycles;
        bit dn;
        en_cycles = 0;
        rd_if.done = 0; wr_if.done = 0; rd_if.data = 0;
        forever begin
            @(negedge clk);
            if (!rst && (rd_if.en || wr_if.en)) begin
                check("rd_wr_exclusive", {31'd0, rd_if.en && wr_if.en}, 0);
                check("rd_en_port", {31'd0, rd_if.en}, {31'd0, exp_bus && exp_read});
                check("wr_en_port", {31'd0, wr_if.en}, {31'd0, exp_bus && !exp_read});
                check("bus_addr", rd_if.en ? rd_if.addr : wr_if.addr, exp_addr);
                check("bus_byte_num", {29'd0, rd_if.en ? rd_if.byte_num : wr_if.byte_num}, {29'd0, exp_bn});
                if (wr_if.en) check("bus_wdata", wr_if.data, exp_wdata);
                en_cycles++;
                dn = mem_stuck || (en_cycles == mem_delay + 2);
            end else begin
                en_cycles = 0;
                dn = mem_stuck;
            end
            rd_if.done = dn;
            wr_if.done = dn;
            rd_if.data = dn ? mem_data : $urandom;
        end
    end

    // Consumer backpressure.
    initial begin : backpressure
        resp_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: every presented response must match the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got rdata %h err %b, none expected", resp_rdata, resp_err);
                end else begin
                    e = exp_q[0];
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    if (resp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int w = 0;
        while (!req_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_ready_wait: got 0 expected 1 after %0d cycles", w);
        end
    endtask

    task automatic set_bus(input bit we, input int size, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit legal);
        exp_bus   = legal;
        exp_read  = !we;
        exp_addr  = addr;
        exp_wdata = wdata;
        exp_bn    = (size < 3) ? 3'(1 << size) : 3'd0;
    endtask

    task automatic drive_req(input bit we, input int size, input bit sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_we = we; req_size = 2'(size); req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic send(input bit we, input int size, input bit sgn, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] md, input int d, input bit stuck);
        int d_eff, lat, en_cnt, exp_lat, exp_en;
        bit ill;
        d_eff = stuck ? 0 : d;
        ill = tb_illegal(size, addr);
        exp_q.push_back(ref_resp(we, size, sgn, addr, md, d_eff));
        if (ill) begin
            exp_lat = 1; exp_en = 0;
        end else if (d_eff >= TO) begin
            exp_lat = 2 + TO; exp_en = 1 + TO;
        end else begin
            exp_lat = 3 + d_eff; exp_en = 2 + d_eff;
        end
        wait_idle();
        mem_delay = d_eff; mem_data = md; mem_stuck = stuck;
        set_bus(we, size, addr, wdata, !ill);
        drive_req(we, size, sgn, addr, wdata);
        lat = 0; en_cnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
            if (rd_if.en || wr_if.en) en_cnt++;
        end
        check("latency", lat, exp_lat);
        check("en_cycles", en_cnt, exp_en);
        @(posedge clk); #1;
    endtask

    task automatic send_flush(input bit we, input int size, input logic [31:0] addr,
                              input logic [31:0] wdata, input int wait_n);
        wait_idle();
        mem_delay = 1000; mem_stuck = 0;
        set_bus(we, size, addr, wdata, 1);
        drive_req(we, size, 0, addr, wdata);
        repeat (wait_n) @(posedge clk);
        #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        check("flush_rd_en", {31'd0, rd_if.en}, 0);
        check("flush_wr_en", {31'd0, wr_if.en}, 0);
        check("flush_req_ready", {31'd0, req_ready}, 1);
        repeat (3) begin
            check("flush_no_resp", {31'd0, resp_valid}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        int size, d, w;
        bit we, stuck;
        logic [31:0] addr;

        rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; flush = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 0);
        check("rst_resp_valid", {31'd0, resp_valid}, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", {31'd0, resp_err}, 0);
        check("rst_rd_en", {31'd0, rd_if.en}, 0);
        check("rst_wr_en", {31'd0, wr_if.en}, 0);
        check("rst_addr", rd_if.addr, 0);
        check("rst_wdata", wr_if.data, 0);
        check("rst_byte_num", {29'd0, wr_if.byte_num}, 0);
        @(posedge clk); #1;
        rst = 0;
        hold_ready = 0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 1);
        @(posedge clk); #1;

        // directed cases
        send(0, 2, 1, 32'h10, 0, 32'h8000_00F0, 0, 0);      // lw
        send(0, 0, 1, 32'h03, 0, 32'h1234_56F0, 1, 0);      // lb
        send(0, 0, 0, 32'h03, 0, 32'h1234_56F0, 2, 0);      // lbu
        send(0, 1, 0, 32'h02, 0, 32'hABCD_8001, 0, 0);      // lhu
        send(0, 1, 1, 32'h02, 0, 32'hABCD_8001, 3, 0);      // lh
        send(1, 1, 0, 32'h05, 32'h1234, 0, 0, 0);           // misaligned sh
        send(0, 2, 0, 32'h22, 0, 32'h1, 0, 0);              // misaligned lw
        send(0, 3, 0, 32'h40, 0, 32'h1, 0, 0);              // illegal size
        send(1, 2, 0, 32'h20, 32'hDEAD_BEEF, 0, 0, 1);      // sw with stuck done
        send(0, 2, 1, 32'h44, 0, 32'h7FFF_FFFF, 0, 1);      // lw with stuck done
        send(0, 2, 0, 32'h48, 0, 32'hCAFE_F00D, TO - 1, 0); // done on last WAIT cycle
        send(1, 0, 0, 32'h49, 32'h55, 0, TO, 0);            // one cycle too late
        hold_ready = 1;
        send(0, 2, 0, 32'h50, 0, 32'h1, 1000, 0);           // no done: timeout
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        hold_ready = 0;
        send_flush(0, 2, 32'h60, 0, 2);                     // flush in RD_WAIT
        send_flush(1, 1, 32'h62, 32'h77, 0);                // flush in WR_ISSUE

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            we   = 1'($urandom);
            size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) begin
                addr[1:0] = 2'b00;
                send_flush(we, $urandom_range(0, 2), addr, $urandom, $urandom_range(0, 4));
            end else begin
                w = $urandom_range(0, 19);
                if (w < 14)      d = $urandom_range(0, 4);
                else if (w < 18) d = $urandom_range(TO - 2, TO + 1);
                else             d = 1000;
                stuck = ($urandom_range(0, 7) == 0);
                send(we, size, 1'($urandom), addr, $urandom, $urandom, d, stuck);
            end
        end

        // asynchronous reset in the middle of a read
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        mem_delay = 1000; mem_stuck = 0;
        set_bus(0, 2, 32'h80, 0, 1);
        drive_req(0, 2, 0, 32'h80, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1;
        #1;
        check("async_rst_rd_en", {31'd0, rd_if.en}, 0);
        check("async_rst_resp_valid", {31'd0, resp_valid}, 0);
        check("async_rst_req_ready", {31'd0, req_ready}, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("after_rst_req_ready", {31'd0, req_ready}, 1);
        repeat (3) begin
            check("after_rst_no_resp", {31'd0, resp_valid}, 0);
            @(negedge clk);
        end
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
